// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: the CPU MEM-stage port, the external
// debug/loader port and the shared synchronous memory port.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          ext_req;
    logic          ext_we;
    logic          ext_lock;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt;
    logic          ext_rvalid;
    logic [DW-1:0] ext_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
        input  mem_rdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requester / memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
        output mem_rdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one synchronous data-memory port between the CPU (fixed priority) and
// an external master, with a starvation guard, a lock mode and read-data routing.
module dmem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic {ARB, LOCK} state_e;

    localparam logic [3:0]    MAX_W     = 4'(MAX_WAIT);
    localparam logic [AW-1:0] ADDR_IDLE = '0;
    localparam logic [DW-1:0] DATA_IDLE = '0;

    state_e     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       rsp_cpu_q, rsp_cpu_d;
    logic       rsp_ext_q, rsp_ext_d;

    logic ext_prio;
    logic cpu_gnt;
    logic ext_gnt;

    // Grants are qualified by rst_n so every output reads 0 while in reset.
    always_comb begin
        ext_prio = bus.ext_req & ((state_q == LOCK) | (wait_cnt_q == MAX_W));
        cpu_gnt  = rst_n & bus.cpu_req & ~ext_prio;
        ext_gnt  = rst_n & bus.ext_req & ~cpu_gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            wait_cnt_q <= '0;
            rsp_cpu_q  <= 1'b0;
            rsp_ext_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rsp_cpu_q  <= rsp_cpu_d;
            rsp_ext_q  <= rsp_ext_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:  if (ext_gnt && bus.ext_lock) state_d = LOCK;
            LOCK: if (!bus.ext_lock || !bus.ext_req) state_d = ARB;
        endcase

        wait_cnt_d = '0;
        if (bus.ext_req && !ext_gnt)
            wait_cnt_d = (wait_cnt_q == MAX_W) ? wait_cnt_q : wait_cnt_q + 4'd1;

        rsp_cpu_d = cpu_gnt & ~bus.cpu_we;
        rsp_ext_d = ext_gnt & ~bus.ext_we;
    end

    always_comb begin
        bus.cpu_stall  = rst_n & bus.cpu_req & ~cpu_gnt;
        bus.ext_gnt    = ext_gnt;
        bus.mem_en     = cpu_gnt | ext_gnt;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = ADDR_IDLE;
        bus.mem_wdata  = DATA_IDLE;
        if (cpu_gnt) begin
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (ext_gnt) begin
            bus.mem_we    = bus.ext_we;
            bus.mem_addr  = bus.ext_addr;
            bus.mem_wdata = bus.ext_wdata;
        end
        bus.cpu_rvalid = rsp_cpu_q;
        bus.ext_rvalid = rsp_ext_q;
        bus.cpu_rdata  = rsp_cpu_q ? bus.mem_rdata : DATA_IDLE;
        bus.ext_rdata  = rsp_ext_q ? bus.mem_rdata : DATA_IDLE;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: CPU-only reads, contention with the
// starvation guard, locked bursts, read routing, reset mid-read, lock abandonment.
module tb_dmem_arbiter;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();
    dmem_arbiter_if #(.AW(32), .DW(32)) bus1 ();

    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Second instance sees the same requests with the tightest starvation bound.
    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    assign bus1.cpu_req   = bus.cpu_req;
    assign bus1.cpu_we    = bus.cpu_we;
    assign bus1.cpu_addr  = bus.cpu_addr;
    assign bus1.cpu_wdata = bus.cpu_wdata;
    assign bus1.ext_req   = bus.ext_req;
    assign bus1.ext_we    = bus.ext_we;
    assign bus1.ext_lock  = bus.ext_lock;
    assign bus1.ext_addr  = bus.ext_addr;
    assign bus1.ext_wdata = bus.ext_wdata;
    assign bus1.mem_rdata = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory model with one-cycle read latency
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] rd_q;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
            else rd_q <= mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : 32'h0;
        end
    end
    assign bus.mem_rdata = rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.ext_req   = 1'b0;
        bus.ext_we    = 1'b0;
        bus.ext_lock  = 1'b0;
        bus.ext_addr  = '0;
        bus.ext_wdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        rd_q  = '0;
        mem_model[32'h40] = 32'hA5A5_0001;

        // Reset with requests active: every output must be 0
        idle_inputs();
        rst_n        = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h44;
        bus.ext_req  = 1'b1;
        bus.ext_addr = 32'h48;
        #7;
        chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_ext_gnt",   32'(bus.ext_gnt),   32'd0);
        chk("rst_mem_en",    32'(bus.mem_en),    32'd0);
        chk("rst_mem_addr",  bus.mem_addr,       32'h0);
        chk("rst_cpu_rvalid",32'(bus.cpu_rvalid),32'd0);
        chk("rst_ext_rvalid",32'(bus.ext_rvalid),32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // CPU-only reads of 0x40
        tick();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h40;
        #3;
        chk("t1_stall0",   32'(bus.cpu_stall),  32'd0);
        chk("t1_mem_en",   32'(bus.mem_en),     32'd1);
        chk("t1_mem_addr", bus.mem_addr,        32'h40);
        chk("t1_rvalid0",  32'(bus.cpu_rvalid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            #3;
            chk("t1_stall",      32'(bus.cpu_stall),  32'd0);
            chk("t1_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
            chk("t1_cpu_rdata",  bus.cpu_rdata,       32'hA5A5_0001);
            chk("t1_ext_rvalid", 32'(bus.ext_rvalid), 32'd0);
        end
        tick();
        bus.cpu_req = 1'b0;
        #3;
        chk("t1_last_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        chk("t1_last_rdata",  bus.cpu_rdata,       32'hA5A5_0001);
        chk("t1_idle_mem_en", 32'(bus.mem_en),     32'd0);

        // Full contention: ext forced in every fifth cycle (every second for MAX_WAIT=1)
        tick();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h10;
        bus.ext_req  = 1'b1;
        bus.ext_addr = 32'h20;
        for (int c = 0; c < 10; c++) begin
            if (c != 0) tick();
            #3;
            chk("t2_ext_gnt",    32'(bus.ext_gnt),    32'((c == 4) || (c == 9)));
            chk("t2_cpu_stall",  32'(bus.cpu_stall),  32'((c == 4) || (c == 9)));
            chk("t2_mem_addr",   bus.mem_addr,        ((c == 4) || (c == 9)) ? 32'h20 : 32'h10);
            chk("t2_ext_rvalid", 32'(bus.ext_rvalid), 32'(c == 5));
            chk("t2_cpu_rvalid", 32'(bus.cpu_rvalid), 32'((c != 0) && (c != 5)));
            chk("t2_mw1_ext_gnt",32'(bus1.ext_gnt),   32'(c % 2 == 1));
            chk("t2_mw1_stall",  32'(bus1.cpu_stall), 32'(c % 2 == 1));
        end
        tick();
        idle_inputs();
        #3;
        chk("t2_ext_rvalid_last", 32'(bus.ext_rvalid), 32'd1);

        // Locked write burst 0x100/0x104/0x108 after a forced ext slot
        tick();
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = 32'h30;
        bus.ext_req   = 1'b1;
        bus.ext_we    = 1'b1;
        bus.ext_lock  = 1'b1;
        bus.ext_addr  = 32'h100;
        bus.ext_wdata = 32'h1111_0000;
        for (int c = 0; c < 8; c++) begin
            if (c != 0) tick();
            if (c == 5) begin bus.ext_addr = 32'h104; bus.ext_wdata = 32'h1111_0004; end
            if (c == 6) begin bus.ext_addr = 32'h108; bus.ext_wdata = 32'h1111_0008; bus.ext_lock = 1'b0; end
            if (c == 7) begin bus.ext_addr = 32'h10C; bus.ext_wdata = 32'h1111_000C; end
            #3;
            chk("t3_ext_gnt",   32'(bus.ext_gnt),   32'((c >= 4) && (c <= 6)));
            chk("t3_cpu_stall", 32'(bus.cpu_stall), 32'((c >= 4) && (c <= 6)));
            chk("t3_mem_we",    32'(bus.mem_we),    32'((c >= 4) && (c <= 6)));
            chk("t3_mem_addr",  bus.mem_addr,
                ((c >= 4) && (c <= 6)) ? 32'h100 + 32'(4 * (c - 4)) : 32'h30);
        end
        tick();
        idle_inputs();
        #3;

        // Ext write followed by CPU read of the same word
        tick();
        bus.ext_req   = 1'b1;
        bus.ext_we    = 1'b1;
        bus.ext_addr  = 32'h200;
        bus.ext_wdata = 32'hDEAD_BEEF;
        #3;
        chk("t4_ext_gnt",   32'(bus.ext_gnt), 32'd1);
        chk("t4_mem_we",    32'(bus.mem_we),  32'd1);
        chk("t4_mem_wdata", bus.mem_wdata,    32'hDEAD_BEEF);
        tick();
        idle_inputs();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h200;
        #3;
        chk("t4_cpu_stall",  32'(bus.cpu_stall),  32'd0);
        chk("t4_mem_addr",   bus.mem_addr,        32'h200);
        chk("t4_wr_ext_rv",  32'(bus.ext_rvalid), 32'd0);
        chk("t4_wr_cpu_rv",  32'(bus.cpu_rvalid), 32'd0);
        tick();
        bus.cpu_req = 1'b0;
        #3;
        chk("t4_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        chk("t4_cpu_rdata",  bus.cpu_rdata,       32'hDEAD_BEEF);
        chk("t4_ext_rvalid", 32'(bus.ext_rvalid), 32'd0);

        // Reset asserted while an ext read is in flight
        tick();
        bus.ext_req  = 1'b1;
        bus.ext_lock = 1'b1;
        bus.ext_addr = 32'h104;
        #3;
        chk("t5_ext_gnt", 32'(bus.ext_gnt), 32'd1);
        rst_n        = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h50;
        #1;
        chk("t5_rst_mem_en",  32'(bus.mem_en),  32'd0);
        chk("t5_rst_ext_gnt", 32'(bus.ext_gnt), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            #3;
            chk("t5_rst_ext_rvalid", 32'(bus.ext_rvalid), 32'd0);
            chk("t5_rst_ext_rdata",  bus.ext_rdata,       32'h0);
            chk("t5_rst_cpu_stall",  32'(bus.cpu_stall),  32'd0);
            chk("t5_rst_mem_en",     32'(bus.mem_en),     32'd0);
            chk("t5_rst_mem_addr",   bus.mem_addr,        32'h0);
        end
        rst_n = 1'b1;
        #1;
        chk("t5_rel_cpu_stall",  32'(bus.cpu_stall),  32'd0);
        chk("t5_rel_ext_gnt",    32'(bus.ext_gnt),    32'd0);
        chk("t5_rel_ext_rvalid", 32'(bus.ext_rvalid), 32'd0);
        for (int c = 1; c < 5; c++) begin
            tick();
            #3;
            chk("t5_ext_gnt_cnt",  32'(bus.ext_gnt),    32'(c == 4));
            chk("t5_ext_rvalid",   32'(bus.ext_rvalid), 32'd0);
        end

        // Lock abandonment: ext_req drops while ext_lock stays high
        tick();
        #3;
        chk("t6_lock_ext_gnt", 32'(bus.ext_gnt),    32'd1);
        chk("t6_lock_stall",   32'(bus.cpu_stall),  32'd1);
        chk("t6_ext_rvalid",   32'(bus.ext_rvalid), 32'd1);
        tick();
        bus.ext_req = 1'b0;
        #3;
        chk("t6_abandon_stall",  32'(bus.cpu_stall), 32'd0);
        chk("t6_abandon_mem_en", 32'(bus.mem_en),    32'd1);
        chk("t6_abandon_addr",   bus.mem_addr,       32'h50);
        tick();
        bus.ext_req = 1'b1;
        #3;
        chk("t6_arb_ext_gnt", 32'(bus.ext_gnt),   32'd0);
        chk("t6_arb_stall",   32'(bus.cpu_stall), 32'd0);
        tick();
        idle_inputs();
        #3;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
